// File: rtl/mdu_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_unit
// Brief    : Radix-2 restoring divider for DIV/DIVU; optional abort port
//            guarded by MDU_DIV_CANCEL_EN.
// Revision : 1.0
// ============================================================================
module mdu_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_DIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             div_zero;

    logic             kill;
    logic [WIDTH:0]   shifted;
    logic             no_borrow;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             neg_a;
    logic             neg_b;

`ifdef MDU_DIV_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign neg_a     = signed_div & a[WIDTH-1];
    assign neg_b     = signed_div & b[WIDTH-1];

    // One restoring step: the compare against the WIDTH+1 bit shifted remainder is the borrow test.
    assign shifted   = {rem, quo[WIDTH-1]};
    assign no_borrow = (shifted >= {1'b0, divisor});
    assign diff      = shifted[WIDTH-1:0] - divisor;

    // Divide by zero leaves quo all ones and rem = |a|; re-negating rem by sign_r restores raw a.
    assign q_fix     = (sign_q & ~div_zero) ? -quo : quo;
    assign r_fix     = sign_r ? -rem : rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            divisor   <= '0;
            rem       <= '0;
            quo       <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            div_zero  <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                // An abort flushes the in-flight op and also suppresses a same-cycle launch.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            quo      <= neg_a ? -a : a;
                            divisor  <= neg_b ? -b : b;
                            sign_q   <= neg_a ^ neg_b;
                            sign_r   <= neg_a;
                            div_zero <= (b == '0);
                            rem      <= '0;
                            count    <= '0;
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        rem   <= no_borrow ? diff : shifted[WIDTH-1:0];
                        quo   <= {quo[WIDTH-2:0], no_borrow};
                        count <= count + CW'(1);
                        if (count == LAST_STEP) begin
                            state <= FIN;
                        end
                    end
                    FIN: begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_div_unit
// Brief    : Directed self-checking bench for mdu_div_unit (WIDTH = 32).
// Revision : 1.0
// ============================================================================
module tb_mdu_div_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    int checks = 0;
    int errors = 0;

    mdu_div_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
`ifdef MDU_DIV_CANCEL_EN
        .cancel     (cancel),
`endif
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch at the next edge; lat counts sampled cycles up to and including the done cycle.
    task automatic do_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int bcnt);
        start      = 1'b1;
        signed_div = sd;
        a          = av;
        b          = bv;
        lat        = 0;
        bcnt       = 0;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        int bcnt;
        do_div(sd, av, bv, lat, bcnt);
        check({tag, " lat"}, lat, 34);
        check({tag, " busy_cycles"}, bcnt, 33);
        check({tag, " busy_at_done"}, {31'd0, busy}, 0);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        tick();
        check({tag, " done_width"}, {31'd0, done}, 0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int ndone;

        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        cancel     = 1'b0;
        #12;
        check("rst busy", {31'd0, busy}, 0);
        check("rst done", {31'd0, done}, 0);
        check("rst quotient", quotient, 0);
        check("rst remainder", remainder, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        run_vec("divu_100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
        run_vec("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
        run_vec("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
        run_vec("div_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE);
        run_vec("divu_5_0",    1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5);
        run_vec("div_m5_0",    1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB);
        run_vec("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
        run_vec("divu_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0);
        run_vec("divu_big",    1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF);

        // Start pulsed mid-divide with new operands must be ignored.
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        start = 1'b1; a = 32'd50; b = 32'd5;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("ignore lat_after_poke", lat, 23);
        check("ignore quotient", quotient, 32'd333);
        check("ignore remainder", remainder, 32'd1);

        // Back-to-back launch in the done cycle.
        do_div(1'b0, 32'd81, 32'd9, lat, bcnt);
        check("b2b lat", lat, 34);
        check("b2b quotient", quotient, 32'd9);
        check("b2b remainder", remainder, 32'd0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (done) ndone++;
        end
        check("b2b extra_done", ndone, 0);

        // Reset mid-RUN: outputs clear at once and no done follows.
        start = 1'b1; signed_div = 1'b0; a = 32'd77; b = 32'd4;
        tick();
        start = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy}, 0);
        check("midrst done", {31'd0, done}, 0);
        check("midrst quotient", quotient, 0);
        check("midrst remainder", remainder, 0);
        @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        repeat (40) begin
            tick();
            if (done || busy) ndone++;
        end
        check("midrst no_activity", ndone, 0);

`ifdef MDU_DIV_CANCEL_EN
        run_vec("pre_cancel", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        start = 1'b1; signed_div = 1'b0; a = 32'd500; b = 32'd6;
        tick();
        start = 1'b0;
        repeat (19) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy", {31'd0, busy}, 0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (done) ndone++;
        end
        check("cancel no_done", ndone, 0);
        check("cancel quotient_held", quotient, 32'd14);
        check("cancel remainder_held", remainder, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
